// File: rtl/lstm_neuron_mac.sv
// lstm_neuron_mac: streamed MAC neuron, z = sum(x*w) + bias, Q4.4 result.
// Build option NEURON_MAC_SAT_EN: clamp result instead of two's-complement wrap.
module lstm_neuron_mac #(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 20,
    parameter int CNT_W    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bias,
    input  logic       x_valid,
    output logic       x_ready,
    input  logic [7:0] x_data,
    input  logic [7:0] w_data,
    output logic       z_valid,
    input  logic       z_ready,
    output logic [7:0] z_value,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ROUND,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] HALF_LSB = 8;
    localparam logic signed [ACC_W-1:0] SAT_MAX = 127;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -128;

    state_t state;
    state_t state_nxt;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [15:0]      prod;
    logic [CNT_W-1:0]        cnt;
    logic [7:0]              z_q;
    logic [7:0]              z_rnd;
    logic                    take;
    logic                    last;

    // Q4.4 x Q4.4 gives a Q8.8 product; bias is shifted up to the same scale
    assign prod = $signed({{8{x_data[7]}}, x_data})
                * $signed({{8{w_data[7]}}, w_data});
    assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
    assign bias_ext = {{(ACC_W-12){bias[7]}}, bias, 4'b0000};

    // round half up back to Q4.4
    assign rnd = (acc + HALF_LSB) >>> 4;

    assign take = (state == ACCUM) && x_valid;
    assign last = (cnt == LAST_CNT);

    assign x_ready = (state == ACCUM);
    assign z_valid = (state == DONE);
    assign busy    = (state != IDLE);
    assign z_value = z_q;

`ifdef NEURON_MAC_SAT_EN
    // clamp the rounded sum into the signed 8-bit range
    always_comb begin
        z_rnd = rnd[7:0];
        if (rnd > SAT_MAX) begin
            z_rnd = 8'h7F;
        end else if (rnd < SAT_MIN) begin
            z_rnd = 8'h80;
        end
    end
`else
    logic unused_hi;
    assign unused_hi = ^rnd[ACC_W-1:8];

    // keep the low byte; out-of-range sums wrap
    always_comb begin
        z_rnd = rnd[7:0];
    end
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (take && last) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (z_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // accumulator, element counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
            z_q <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc <= bias_ext;
                        cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (take) begin
                        acc <= acc + prod_ext;
                        cnt <= cnt + 1'b1;
                    end
                end
                ROUND: begin
                    z_q <= z_rnd;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lstm_neuron_mac.sv
// tb_lstm_neuron_mac: vector table plus scoreboard for lstm_neuron_mac.
// Expected results follow NEURON_MAC_SAT_EN when the bench shares the define.
module tb_lstm_neuron_mac;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] bias;
    logic       x_valid;
    logic       x_ready;
    logic [7:0] x_data;
    logic [7:0] w_data;
    logic       z_valid;
    logic       z_ready;
    logic [7:0] z_value;
    logic       busy;

    typedef struct packed {
        logic [7:0]      b;
        logic [3:0][7:0] x;
        logic [3:0][7:0] w;
        logic [7:0]      z;
    } vec_t;

    int         total = 0;
    int         bad = 0;
    logic [7:0] sb[$];
    vec_t       vecs[8];
    vec_t       basic;

    lstm_neuron_mac #(
        .N_INPUTS(N),
        .ACC_W(20),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .bias(bias),
        .x_valid(x_valid),
        .x_ready(x_ready),
        .x_data(x_data),
        .w_data(w_data),
        .z_valid(z_valid),
        .z_ready(z_ready),
        .z_value(z_value),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic [7:0] b, logic [31:0] xs,
                                logic [31:0] ws, logic [7:0] z);
        vec_t v;
        v.b = b;
        for (int k = 0; k < 4; k++) begin
            v.x[k] = xs[31-8*k -: 8];
            v.w[k] = ws[31-8*k -: 8];
        end
        v.z = z;
        return v;
    endfunction

    // every completed output handshake pops one expected result
    always @(negedge clk) begin
        if (rst === 1'b0 && z_valid === 1'b1 && z_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_z: got %h want none", z_value);
            end else begin
                chk("sb_z", z_value, sb.pop_front());
            end
        end
    end

    task automatic wait_z();
        int n;
        n = 0;
        while (z_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL z_timeout: got no z_valid want z_valid");
        end
    endtask

    task automatic sb_empty(string name);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d pending want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_eval(vec_t v, bit bub);
        int i;
        int guard;
        sb.push_back(v.z);
        start = 1'b1;
        bias = v.b;
        tick();
        start = 1'b0;
        bias = 8'h55;
        chk("x_ready_after_start", x_ready, 1'b1);
        i = 0;
        guard = 0;
        while (i < N && guard < 200) begin
            x_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
            x_data = v.x[i];
            w_data = v.w[i];
            tick();
            if (x_valid) i++;
            guard++;
        end
        x_valid = 1'b0;
        if (!bub) begin
            chk("lat_t1_ready", x_ready, 1'b0);
            chk("lat_t1_valid", z_valid, 1'b0);
            tick();
            chk("lat_t2_valid", z_valid, 1'b1);
        end else begin
            wait_z();
        end
        tick();
        chk("one_cycle_valid", z_valid, 1'b0);
        sb_empty("sb_drain");
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bias = 8'h00;
        x_valid = 1'b0;
        x_data = 8'h00;
        w_data = 8'h00;
        z_ready = 1'b1;

        vecs[0] = mk(8'h00, 32'h10200800, 32'h10101010, 8'h38);
        vecs[1] = mk(8'h10, 32'h01000000, 32'h08000000, 8'h11);
        vecs[2] = mk(8'h10, 32'h01000000, 32'h07000000, 8'h10);
`ifdef NEURON_MAC_SAT_EN
        vecs[3] = mk(8'h00, 32'h7F7F7F7F, 32'h7F7F7F7F, 8'h7F);
        vecs[4] = mk(8'h00, 32'h80808080, 32'h7F7F7F7F, 8'h80);
`else
        vecs[3] = mk(8'h00, 32'h7F7F7F7F, 32'h7F7F7F7F, 8'hC0);
        vecs[4] = mk(8'h00, 32'h80808080, 32'h7F7F7F7F, 8'h20);
`endif
        vecs[5] = mk(8'h00, 32'hF7000000, 32'h01000000, 8'hFF);
        vecs[6] = mk(8'hF0, 32'hF8000000, 32'h01000000, 8'hF0);
        vecs[7] = mk(8'h80, 32'h00000000, 32'h00000000, 8'h80);
        basic = vecs[0];

        tick();
        tick();
        chk("rst_x_ready", x_ready, 1'b0);
        chk("rst_z_valid", z_valid, 1'b0);
        chk("rst_z_value", z_value, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) begin
            run_eval(vecs[k], 1'b0);
            run_eval(vecs[k], 1'b1);
        end

        // backpressure, extra 5th pair, start pulses while busy
        z_ready = 1'b0;
        sb.push_back(8'h38);
        start = 1'b1;
        bias = basic.b;
        tick();
        bias = 8'hAA;
        for (int k = 0; k < N; k++) begin
            start = (k == 1);
            x_valid = 1'b1;
            x_data = basic.x[k];
            w_data = basic.w[k];
            tick();
        end
        start = 1'b0;
        x_data = 8'h7F;
        w_data = 8'h7F;
        chk("no_5th_ready", x_ready, 1'b0);
        tick();
        chk("bp_valid_t2", z_valid, 1'b1);
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            chk("bp_hold_valid", z_valid, 1'b1);
            chk("bp_hold_value", z_value, 8'h38);
            tick();
        end
        start = 1'b0;
        x_valid = 1'b0;
        z_ready = 1'b1;
        tick();
        chk("bp_released", z_valid, 1'b0);
        chk("bp_idle", busy, 1'b0);
        repeat (3) tick();
        chk("single_eval_idle", busy, 1'b0);
        sb_empty("bp_drain");

        // reset after the 2nd acceptance
        start = 1'b1;
        bias = basic.b;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            x_valid = 1'b1;
            x_data = basic.x[k];
            w_data = basic.w[k];
            tick();
        end
        rst = 1'b1;
        x_data = basic.x[2];
        w_data = basic.w[2];
        tick();
        chk("mid_rst_x_ready", x_ready, 1'b0);
        chk("mid_rst_z_valid", z_valid, 1'b0);
        chk("mid_rst_z_value", z_value, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        x_valid = 1'b0;
        repeat (4) tick();
        chk("post_rst_idle", busy, 1'b0);
        run_eval(basic, 1'b0);

        repeat (3) tick();
        chk("end_idle", busy, 1'b0);
        sb_empty("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lstm_neuron_mac.md
# lstm_neuron_mac

Sequential multiply-accumulate neuron core for the LSTM hardware. It computes the pre-activation z = Σ x_i·w_i + bias over N_INPUTS streamed operand pairs, one pair per cycle. It rounds and saturates z to 8-bit signed Q4.4 and presents it on a valid/ready output. It sits directly upstream of the tanh activation unit: that unit uses z_value[7:4] as its LUT address and z_value[3:0] as its interpolation remainder, with 1.0 = 0x10.

## Interface
Parameters:
- N_INPUTS, 4, operand pairs per neuron evaluation (≥1)
- ACC_W, 20, accumulator width; must be ≥ 16 + clog2(N_INPUTS+1)
- CNT_W, 3, element counter width; must hold N_INPUTS

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin an evaluation; sampled only in IDLE
- bias  in  8  signed Q4.4 bias; sampled on the accepted start cycle
- x_valid  in  1  operand pair valid
- x_ready  out  1  core accepts an operand pair
- x_data  in  8  signed Q4.4 input
- w_data  in  8  signed Q4.4 weight
- z_valid  out  1  result valid
- z_ready  in  1  downstream (tanh stage) accepts result
- z_value  out  8  signed Q4.4 pre-activation result
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ACCUM, ROUND, DONE.
- IDLE:
  - On start=1: acc ← sign_ext(bias) << 4 (bias aligned to Q.8), cnt ← 0, go to ACCUM.
  - Otherwise stay in IDLE.
- ACCUM:
  - x_ready=1.
  - On x_valid && x_ready: acc ← acc + sign_ext(x_data·w_data), where the product is a 16-bit signed Q8.8 value; cnt ← cnt+1.
  - When the accepted pair is number N_INPUTS (cnt = N_INPUTS-1 at acceptance), go to ROUND.
  - With x_valid=0, hold acc and cnt (bubbles allowed).
- ROUND:
  - r = (acc + 8) >>> 4, an arithmetic shift giving round-half-up to Q4.4.
  - z_value ← sat8(r), clamped to [-128, 127].
  - Go to DONE.
- DONE:
  - z_valid=1.
  - z_value stays stable until z_valid && z_ready, then the FSM returns to IDLE.
- start is ignored outside IDLE. Holding start high re-arms on the cycle after the return to IDLE.
- Accumulator never overflows for legal ACC_W: the worst case is N·16384 + 2048.

## Timing
- Reset values: x_ready=0, z_valid=0, z_value=0x00, busy=0; state=IDLE, acc=0, cnt=0.
- rst has priority over every other input. Reset mid-evaluation discards the partial sum, and no z_valid follows.
- Cycle after accepted start: x_ready=1.
- Throughput: 1 pair per cycle. With no bubbles, the minimum evaluation is 1 (start) + N_INPUTS + 1 (ROUND) cycles to z_valid.
- Last pair accepted at cycle t: z_valid=1 at t+2.
- x_ready drops in the cycle after the last acceptance, so pair N_INPUTS+1 is never consumed.
- With z_ready held high, z_valid is high for exactly one cycle. Otherwise it stays high until the handshake.
- Back-to-back: start sampled in the first IDLE cycle after the DONE handshake.

## Configuration
- NEURON_MAC_SAT_EN:
  - Defined: ROUND clamps r to [-128, 127], i.e. 0x80..0x7F.
  - Undefined: ROUND takes r[7:0] (two's-complement wrap) and drops the saturation logic.
  - Rounding is identical in both builds.

## Test plan
- Basic sum (N=4): bias=0x00; x={0x10,0x20,0x08,0x00}, w=0x10 each, no bubbles → z_value=0x38 (3.5) and z_valid exactly 2 cycles after the 4th acceptance.
- Bias plus rounding: bias=0x10; x={0x01,0,0,0}, w={0x08,0,0,0} → 0x11 (half rounds up). Same with w=0x07 → 0x10.
- Saturation with NEURON_MAC_SAT_EN:
  - x=0x7F, w=0x7F ×4 → 0x7F.
  - x=0x80, w=0x7F ×4 → 0x80.
  - Without the macro, the positive case gives 0xC0.
- Handshake/backpressure:
  - Random x_valid bubbles give the same result as the no-bubble run.
  - z_ready held 0 for 5 cycles → z_valid and z_value stable for all 5.
  - A 5th pair offered while x_ready=0 is not consumed.
- Reset mid-operation: rst asserted after the 2nd acceptance → next cycle all outputs at reset values. A fresh evaluation then yields the basic-sum result 0x38.
- start while busy: pulsing start during ACCUM and DONE leaves the result unchanged. A single evaluation completes, then IDLE.
